// File: rtl/phy_defs.sv
// Shared PHY definitions: symbol defaults, frame geometry and link state encoding
// used by both the PHY transmitter and the PHY receiver.
package phy_defs;

  localparam int unsigned FRAME_W = 32;
  localparam int unsigned CNT_W   = 5;
  localparam int unsigned BYTE_W  = 8;

  localparam logic [BYTE_W-1:0] COM_DEFAULT  = 8'hBC;
  localparam logic [BYTE_W-1:0] IDLE_DEFAULT = 8'h7C;

  typedef enum logic {
    ST_SYNC   = 1'b0,
    ST_ACTIVE = 1'b1
  } phy_state_t;

  // Substitute the idle symbol on lanes that carry no valid data.
  function automatic logic [BYTE_W-1:0] lane_byte(
    input logic              valid,
    input logic [BYTE_W-1:0] data,
    input logic [BYTE_W-1:0] idle
  );
    return valid ? data : idle;
  endfunction

endpackage

// File: rtl/tx_frame_shifter.sv
// 32-bit loadable shift register with free-running bit counter; strobes the
// cycle before each frame boundary so the parent can present the next frame.
module tx_frame_shifter
  import phy_defs::*;
#(
  parameter logic [FRAME_W-1:0] RESET_WORD = '1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [FRAME_W-1:0] i_load_word,
  output logic               o_bit,
  output logic               o_boundary
);

  logic [CNT_W-1:0]   r_cnt;
  logic [FRAME_W-1:0] r_sr;
  logic               w_last_bit;

  assign w_last_bit = (r_cnt == '1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
      r_sr  <= RESET_WORD;
    end else begin
      r_cnt <= r_cnt + 1'b1;
      if (w_last_bit) begin
        r_sr <= i_load_word;
      end else begin
        r_sr <= {r_sr[FRAME_W-2:0], 1'b0};
      end
    end
  end

  assign o_bit      = r_sr[FRAME_W-1];
  assign o_boundary = w_last_bit;

endmodule

// File: rtl/phy_tx.sv
// PHY transmitter: sends SYNC_FRAMES comma frames after reset, then serializes
// four byte lanes (lane0 first, MSB first) with idle fill for invalid lanes.
module phy_tx
  import phy_defs::*;
#(
  parameter int unsigned SYNC_FRAMES = 2,
  parameter logic [7:0]  COM         = COM_DEFAULT,
  parameter logic [7:0]  IDLE        = IDLE_DEFAULT
) (
  input  logic       clk32f,
  input  logic       reset,
  input  logic [7:0] in0,
  input  logic [7:0] in1,
  input  logic [7:0] in2,
  input  logic [7:0] in3,
  input  logic [3:0] valid_in,
  input  logic       tx_en,
  output logic       out,
  output logic       load_ack,
  output logic       active
);

  localparam logic [CNT_W-1:0]   SYNC_LIM = CNT_W'(SYNC_FRAMES);
  localparam logic [FRAME_W-1:0] COM_WORD = {4{COM}};
  localparam logic [FRAME_W-1:0] IDL_WORD = {4{IDLE}};

  phy_state_t         r_state;
  phy_state_t         w_state_nxt;
  logic [CNT_W-1:0]   r_sync_cnt;
  logic [CNT_W-1:0]   w_sync_cnt_nxt;
  logic               r_load_ack;
  logic               w_load_ack_nxt;
  logic [FRAME_W-1:0] w_frame;
  logic               w_boundary;
  logic               w_bit;

  tx_frame_shifter #(
    .RESET_WORD (COM_WORD)
  ) u_shifter (
    .i_clk       (clk32f),
    .i_rst_n     (reset),
    .i_load_word (w_frame),
    .o_bit       (w_bit),
    .o_boundary  (w_boundary)
  );

  always_ff @(posedge clk32f or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_SYNC;
      r_sync_cnt <= CNT_W'(1);
      r_load_ack <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_sync_cnt <= w_sync_cnt_nxt;
      r_load_ack <= w_load_ack_nxt;
    end
  end

  // The frame loaded at the SYNC->ACTIVE boundary is built from the next state,
  // so the first data capture coincides with the state change.
  always_comb begin
    w_state_nxt    = r_state;
    w_sync_cnt_nxt = r_sync_cnt;
    w_load_ack_nxt = 1'b0;
    w_frame        = COM_WORD;
    if (w_boundary) begin
      case (r_state)
        ST_SYNC: begin
          if (r_sync_cnt >= SYNC_LIM) begin
            w_state_nxt = ST_ACTIVE;
          end else begin
            w_sync_cnt_nxt = r_sync_cnt + 1'b1;
          end
        end
        default: w_state_nxt = ST_ACTIVE;
      endcase
      if (w_state_nxt == ST_ACTIVE) begin
        if (tx_en) begin
          w_frame = {lane_byte(valid_in[0], in0, IDLE),
                     lane_byte(valid_in[1], in1, IDLE),
                     lane_byte(valid_in[2], in2, IDLE),
                     lane_byte(valid_in[3], in3, IDLE)};
          w_load_ack_nxt = 1'b1;
        end else begin
          w_frame = IDL_WORD;
        end
      end
    end
  end

  assign out      = w_bit;
  assign load_ack = r_load_ack;
  assign active   = (r_state == ST_ACTIVE);

endmodule
